i2c_slave_ctrl: RTL and testbench
=================================

// Module: i2c_slave_ctrl
// PURPOSE
//  I2C target (slave) engine: the responder end of the I2C master bit/byte controller, used for on-board
//  test loopback and FPGA-as-peripheral builds. Watches the SCL/SDA inputs and detects START, repeated START
//  and STOP. Matches the 7-bit address, ACKs, then moves bytes to/from a local byte interface. Stretches SCL
//  while waiting for transmit data.
// PARAMETERS
//  SLV_ADDR  7'h50  7-bit address this target answers to
// PORTS
//  clk        in   1  system clock; single clock domain
//  rstn       in   1  reset, synchronous, active-low
//  scl_i      in   1  SCL line input (asynchronous)
//  scl_oen    out  1  SCL output enable, active-low (0 = pull SCL low, i.e. stretch)
//  sda_i      in   1  SDA line input (asynchronous)
//  sda_oen    out  1  SDA output enable, active-low (0 = pull SDA low)
//  busy       out  1  1 from address match until STOP, NACKed read, or non-matching address
//  rw         out  1  R/W bit of the last matched address (1 = master reads)
//  rx_data    out  8  last byte written by the master; valid when rx_valid
//  rx_valid   out  1  1-clk pulse after the 8th data bit of a write byte
//  tx_req     out  1  1-clk pulse requesting the next read byte
//  tx_data    in   8  read byte; sampled when tx_valid=1 in TX_LOAD
//  tx_valid   in   1  tx_data valid; may be held high; only observed in TX_LOAD
// BEHAVIOUR
//  - Reset values: scl_oen=1, sda_oen=1, busy=0, rw=0, rx_data=8'h00, rx_valid=0, tx_req=0, state=IDLE.
//  - Input sampling: scl_i and sda_i pass through a 2-FF synchronizer (reset value 1), then a delay FF.
//    Edges (scl_rise, scl_fall, sda edges) are derived from the synchronized and delayed samples.
//  - START = SDA falls while SCL is high. STOP = SDA rises while SCL is high.
//    Both are detected in every state and take priority over bit processing in the same cycle.
//  - START (including repeated START) -> ADDR; bit counter cleared; sda_oen=1; scl_oen=1.
//  - STOP -> IDLE; sda_oen=1; scl_oen=1; busy=0.
//  - Bits are sampled on scl_rise. The target changes SDA only on scl_fall, never while SCL is high.
//  - Bit counter is 3 bits and wraps 7 -> 0 at each byte boundary. Shift register is MSB first.
//  - States:
//    IDLE:      outputs released; waits for START.
//    ADDR:      shift 8 bits. On the 8th scl_rise compare shift[7:1] with SLV_ADDR.
//               Match: latch rw=shift[0], set busy=1, and drive sda_oen=0 at the next scl_fall -> ADDR_ACK.
//               Miss: -> IDLE; no ACK; rx/tx strobes stay silent.
//    ADDR_ACK:  ACK held through one SCL high. At the next scl_fall: sda_oen=1; rw=0 -> RX, rw=1 -> TX_LOAD.
//    RX:        shift 8 bits. On the 8th scl_rise: rx_data<=byte and rx_valid pulses for 1 clk.
//               Next scl_fall: sda_oen=0 -> RX_ACK. The target always ACKs write bytes.
//    RX_ACK:    at scl_fall: sda_oen=1 -> RX.
//    TX_LOAD:   on entry, tx_req pulses for 1 clk; scl_oen=0 within 1 clk of entry (SCL is low, so this stretches it).
//               When tx_valid=1: load tx_data, drive sda_oen=tx_data[7], and after 1 more clk set scl_oen=1 -> TX.
//               If tx_valid is high on the entry cycle, no stretch beyond 2 clk.
//    TX:        at each scl_fall drive the next bit. After the fall that ends bit 0: sda_oen=1 -> TX_ACK.
//    TX_ACK:    sample SDA on scl_rise. ACK (0) -> TX_LOAD at the next scl_fall.
//               NACK (1) -> IDLE with busy=0; lines stay released until the next START.
//  - Arbitration: in TX, if sda_oen=1 but SDA is sampled 0 on scl_rise, the target abandons the
//    transfer -> IDLE, busy=0.
//  - A STOP or START during TX_LOAD releases scl_oen in the same cycle it is detected; tx_req is not re-issued.
//  - Reset mid-transfer releases both lines on the next clk edge with rstn=0.
// TESTING
//  T1 write: START, 0xA0 (0x50,W), 0x3C, STOP -> ACK on both 9th bits; rx_data=8'h3C with a single
//     rx_valid pulse; busy 1 -> 0 at STOP.
//  T2 read: START, 0xA1, tx_data=8'hA5 given 5 clk after tx_req, master ACK, second byte 8'h0F, master NACK,
//     STOP -> SCL stretched exactly until tx_valid; bytes A5 then 0F on SDA; 2 tx_req pulses; busy=0 after NACK.
//  T3 miss: START, 0xA2 (0x51) -> SDA never driven low, no rx_valid/tx_req, busy stays 0.
//  T4 repeated START: write 0xA0, 0x10, then Sr, 0xA1, read 1 byte -> rw switches 0 -> 1; one rx_valid (8'h10);
//     one tx_req.
//  T5 abort: STOP inserted after bit 3 of an RX byte, and rstn=0 during TX_LOAD stretch -> no rx_valid;
//     scl_oen=1 and sda_oen=1 on the next clk; state IDLE.

Source files
------------

// File: rtl/i2c_slave_ctrl.sv
// I2C target engine: detects START/Sr/STOP on synchronized SCL/SDA, matches a
// 7-bit address, ACKs writes, serves reads from a local byte interface and
// stretches SCL while the next read byte is outstanding.
module i2c_slave_ctrl #(
  parameter logic [6:0] SLV_ADDR = 7'h50
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic       scl_i,
  output logic       scl_oen,
  input  logic       sda_i,
  output logic       sda_oen,
  output logic       busy,
  output logic       rw,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       tx_req,
  input  logic [7:0] tx_data,
  input  logic       tx_valid
);

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_ADDR     = 3'd1,
    ST_ADDR_ACK = 3'd2,
    ST_RX       = 3'd3,
    ST_RX_ACK   = 3'd4,
    ST_TX_LOAD  = 3'd5,
    ST_TX       = 3'd6,
    ST_TX_ACK   = 3'd7
  } state_t;

  logic [1:0] scl_sync_q, sda_sync_q;
  logic       scl_dly_q, sda_dly_q;
  logic       scl_s, sda_s;
  logic       scl_rise_s, scl_fall_s, start_s, stop_s;

  state_t     state_q, state_d;
  logic [2:0] cnt_q, cnt_d;
  logic [7:0] shift_q, shift_d;
  logic       done_q, done_d;       // byte (or ACK bit) finished, act at next SCL fall
  logic       loaded_q, loaded_d;   // read byte captured, release SCL next clk
  logic       scl_oen_q, scl_oen_d;
  logic       sda_oen_q, sda_oen_d;
  logic       busy_q, busy_d;
  logic       rw_q, rw_d;
  logic [7:0] rx_data_q, rx_data_d;
  logic       rx_valid_q, rx_valid_d;
  logic       tx_req_q, tx_req_d;

  assign scl_s      = scl_sync_q[1];
  assign sda_s      = sda_sync_q[1];
  assign scl_rise_s = scl_s & ~scl_dly_q;
  assign scl_fall_s = ~scl_s & scl_dly_q;
  // START/STOP need SCL high on both the current and the delayed sample
  assign start_s    = scl_s & scl_dly_q & ~sda_s & sda_dly_q;
  assign stop_s     = scl_s & scl_dly_q & sda_s & ~sda_dly_q;

  assign scl_oen  = scl_oen_q;
  assign sda_oen  = sda_oen_q;
  assign busy     = busy_q;
  assign rw       = rw_q;
  assign rx_data  = rx_data_q;
  assign rx_valid = rx_valid_q;
  assign tx_req   = tx_req_q;

  // Two-stage synchronizer plus one delay stage per line for edge detection
  always_ff @(posedge clk) begin
    if (!rstn) begin
      scl_sync_q <= 2'b11;
      sda_sync_q <= 2'b11;
      scl_dly_q  <= 1'b1;
      sda_dly_q  <= 1'b1;
    end else begin
      scl_sync_q <= {scl_sync_q[0], scl_i};
      sda_sync_q <= {sda_sync_q[0], sda_i};
      scl_dly_q  <= scl_sync_q[1];
      sda_dly_q  <= sda_sync_q[1];
    end
  end

  // Protocol state and registered outputs
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q    <= ST_IDLE;
      cnt_q      <= 3'd0;
      shift_q    <= 8'h00;
      done_q     <= 1'b0;
      loaded_q   <= 1'b0;
      scl_oen_q  <= 1'b1;
      sda_oen_q  <= 1'b1;
      busy_q     <= 1'b0;
      rw_q       <= 1'b0;
      rx_data_q  <= 8'h00;
      rx_valid_q <= 1'b0;
      tx_req_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      shift_q    <= shift_d;
      done_q     <= done_d;
      loaded_q   <= loaded_d;
      scl_oen_q  <= scl_oen_d;
      sda_oen_q  <= sda_oen_d;
      busy_q     <= busy_d;
      rw_q       <= rw_d;
      rx_data_q  <= rx_data_d;
      rx_valid_q <= rx_valid_d;
      tx_req_q   <= tx_req_d;
    end
  end

  // Next-state logic; bus conditions override bit processing
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    shift_d    = shift_q;
    done_d     = done_q;
    loaded_d   = loaded_q;
    scl_oen_d  = scl_oen_q;
    sda_oen_d  = sda_oen_q;
    busy_d     = busy_q;
    rw_d       = rw_q;
    rx_data_d  = rx_data_q;
    rx_valid_d = 1'b0;
    tx_req_d   = 1'b0;

    if (start_s) begin
      state_d   = ST_ADDR;
      cnt_d     = 3'd0;
      done_d    = 1'b0;
      loaded_d  = 1'b0;
      sda_oen_d = 1'b1;
      scl_oen_d = 1'b1;
    end else if (stop_s) begin
      state_d   = ST_IDLE;
      cnt_d     = 3'd0;
      done_d    = 1'b0;
      loaded_d  = 1'b0;
      sda_oen_d = 1'b1;
      scl_oen_d = 1'b1;
      busy_d    = 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          sda_oen_d = 1'b1;
          scl_oen_d = 1'b1;
        end
        ST_ADDR: begin
          if (scl_rise_s) begin
            shift_d = {shift_q[6:0], sda_s};
            cnt_d   = cnt_q + 3'd1;
            if (cnt_q == 3'd7) begin
              if (shift_q[6:0] == SLV_ADDR) begin
                rw_d   = sda_s;
                busy_d = 1'b1;
                done_d = 1'b1;
              end else begin
                state_d = ST_IDLE;
                busy_d  = 1'b0;
              end
            end else begin
              done_d = 1'b0;
            end
          end else if (scl_fall_s && done_q) begin
            done_d    = 1'b0;
            sda_oen_d = 1'b0;
            state_d   = ST_ADDR_ACK;
          end else begin
            done_d = done_q;
          end
        end
        ST_ADDR_ACK: begin
          if (scl_fall_s) begin
            sda_oen_d = 1'b1;
            if (rw_q) begin
              state_d   = ST_TX_LOAD;
              tx_req_d  = 1'b1;
              scl_oen_d = 1'b0;
              loaded_d  = 1'b0;
            end else begin
              state_d = ST_RX;
            end
          end else begin
            sda_oen_d = 1'b0;
          end
        end
        ST_RX: begin
          if (scl_rise_s) begin
            shift_d = {shift_q[6:0], sda_s};
            cnt_d   = cnt_q + 3'd1;
            if (cnt_q == 3'd7) begin
              rx_data_d  = {shift_q[6:0], sda_s};
              rx_valid_d = 1'b1;
              done_d     = 1'b1;
            end else begin
              done_d = 1'b0;
            end
          end else if (scl_fall_s && done_q) begin
            done_d    = 1'b0;
            sda_oen_d = 1'b0;
            state_d   = ST_RX_ACK;
          end else begin
            done_d = done_q;
          end
        end
        ST_RX_ACK: begin
          if (scl_fall_s) begin
            sda_oen_d = 1'b1;
            state_d   = ST_RX;
          end else begin
            sda_oen_d = 1'b0;
          end
        end
        ST_TX_LOAD: begin
          scl_oen_d = 1'b0;
          if (loaded_q) begin
            scl_oen_d = 1'b1;
            loaded_d  = 1'b0;
            cnt_d     = 3'd0;
            done_d    = 1'b0;
            state_d   = ST_TX;
          end else if (tx_valid) begin
            // remaining bits 6..0 wait in shift[7:1]; bit 7 goes straight out
            shift_d   = {tx_data[6:0], 1'b0};
            sda_oen_d = tx_data[7];
            loaded_d  = 1'b1;
          end else begin
            loaded_d = 1'b0;
          end
        end
        ST_TX: begin
          if (scl_rise_s) begin
            if (sda_oen_q && !sda_s) begin
              // someone else holds SDA low: lost arbitration
              state_d = ST_IDLE;
              busy_d  = 1'b0;
            end else begin
              cnt_d  = cnt_q + 3'd1;
              done_d = (cnt_q == 3'd7);
            end
          end else if (scl_fall_s) begin
            if (done_q) begin
              done_d    = 1'b0;
              sda_oen_d = 1'b1;
              state_d   = ST_TX_ACK;
            end else begin
              sda_oen_d = shift_q[7];
              shift_d   = {shift_q[6:0], 1'b0};
            end
          end else begin
            done_d = done_q;
          end
        end
        ST_TX_ACK: begin
          if (scl_rise_s) begin
            if (sda_s) begin
              state_d = ST_IDLE;
              busy_d  = 1'b0;
            end else begin
              done_d = 1'b1;
            end
          end else if (scl_fall_s && done_q) begin
            done_d    = 1'b0;
            state_d   = ST_TX_LOAD;
            tx_req_d  = 1'b1;
            scl_oen_d = 1'b0;
            loaded_d  = 1'b0;
          end else begin
            done_d = done_q;
          end
        end
        default: begin
          state_d   = ST_IDLE;
          sda_oen_d = 1'b1;
          scl_oen_d = 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_i2c_slave_ctrl.sv
// Bench for i2c_slave_ctrl: bit-banged master on a wired-AND bus, a
// transaction-level expectation model and one per-cycle compare process.
module tb_i2c_slave_ctrl;

  logic       clk = 1'b0;
  logic       rstn;
  logic       scl_m, sda_m;
  logic       scl_line, sda_line;
  logic       scl_oen, sda_oen, busy, rw, rx_valid, tx_req, tx_valid;
  logic [7:0] rx_data, tx_data;

  int total = 0;
  int bad = 0;

  // model / monitor state
  logic [7:0] exp_rx_q[$];
  logic [7:0] resp_q[$];
  int   rx_cnt = 0;
  int   treq_cnt = 0;
  int   treq_limit = 0;
  int   run_len = 0;
  int   last_stretch = 0;
  int   resp_delay = 0;
  bit   hold_en = 1'b0;
  logic [7:0] hold_data = 8'h00;
  bit   no_drive = 1'b0;
  logic m_busy, m_rw;
  logic prev_scl = 1'b1;
  logic prev_sda_oen = 1'b1;

  assign scl_line = scl_m & scl_oen;
  assign sda_line = sda_m & sda_oen;

  always #5 clk = ~clk;

  i2c_slave_ctrl #(.SLV_ADDR(7'h50)) dut (
    .clk(clk), .rstn(rstn),
    .scl_i(scl_line), .scl_oen(scl_oen),
    .sda_i(sda_line), .sda_oen(sda_oen),
    .busy(busy), .rw(rw),
    .rx_data(rx_data), .rx_valid(rx_valid),
    .tx_req(tx_req), .tx_data(tx_data), .tx_valid(tx_valid)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // spec rule: only address 0x50 is acknowledged
  function automatic logic model_ack(input logic [7:0] a);
    return (a[7:1] == 7'h50) ? 1'b0 : 1'b1;
  endfunction

  // compare process: checks DUT outputs against the model every clock
  initial begin
    forever begin
      @(negedge clk);
      if (rstn === 1'b1) begin
        if (rx_valid === 1'b1) begin
          rx_cnt++;
          if (exp_rx_q.size() == 0) chk("rx_unexpected", 32'd1, 32'd0);
          else chk("rx_data", 32'(rx_data), 32'(exp_rx_q.pop_front()));
        end
        if (tx_req === 1'b1) begin
          treq_cnt++;
          chk("tx_req_allowed", 32'(treq_cnt <= treq_limit), 32'd1);
        end
        if (scl_line === 1'b1 && prev_scl === 1'b1)
          chk("sda_stable_scl_high", 32'(sda_oen), 32'(prev_sda_oen));
        if (no_drive)
          chk("no_sda_drive", 32'(sda_oen), 32'd1);
        if (scl_oen === 1'b0) run_len++;
        else if (run_len > 0) begin
          last_stretch = run_len;
          run_len = 0;
        end
      end else begin
        run_len = 0;
      end
      prev_scl = scl_line;
      prev_sda_oen = sda_oen;
    end
  end

  // read-data responder: delayed reply or held-valid mode
  initial begin
    tx_valid = 1'b0;
    tx_data  = 8'h00;
    forever begin
      @(negedge clk);
      if (hold_en) begin
        tx_valid = 1'b1;
        tx_data  = hold_data;
      end else begin
        tx_valid = 1'b0;
        if (tx_req === 1'b1 && resp_delay > 0 && resp_q.size() > 0) begin
          repeat (resp_delay) @(posedge clk);
          #1;
          tx_data  = resp_q.pop_front();
          tx_valid = 1'b1;
          @(posedge clk);
          #1;
          tx_valid = 1'b0;
        end
      end
    end
  end

  initial begin
    repeat (60000) @(posedge clk);
    $display("FAIL watchdog: bench exceeded cycle budget");
    $fatal(1, "watchdog");
  end

  task automatic wait_clk(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic scl_release();
    int n;
    n = 0;
    scl_m = 1'b1;
    #1;
    while (scl_line !== 1'b1 && n < 400) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("scl_stretch_bounded", 32'(scl_line), 32'd1);
  endtask

  task automatic bus_bit(input logic b, output logic r);
    sda_m = b;
    wait_clk(4);
    scl_release();
    wait_clk(4);
    r = sda_line;
    wait_clk(4);
    scl_m = 1'b0;
    wait_clk(4);
  endtask

  task automatic bus_start();
    sda_m = 1'b1;
    wait_clk(4);
    scl_release();
    wait_clk(8);
    sda_m = 1'b0;
    wait_clk(8);
    scl_m = 1'b0;
    wait_clk(4);
  endtask

  task automatic bus_stop();
    sda_m = 1'b0;
    wait_clk(4);
    scl_release();
    wait_clk(8);
    sda_m = 1'b1;
    wait_clk(8);
  endtask

  task automatic write_byte(input logic [7:0] b, output logic ack);
    logic r;
    for (int i = 7; i >= 0; i--) bus_bit(b[i], r);
    bus_bit(1'b1, ack);
  endtask

  task automatic read_byte(output logic [7:0] d, input logic ack);
    logic r;
    logic [7:0] v;
    v = 8'h00;
    for (int i = 7; i >= 0; i--) begin
      bus_bit(1'b1, r);
      v[i] = r;
    end
    bus_bit(ack, r);
    d = v;
  endtask

  task automatic check_status(input string tag);
    chk({tag, "_busy"}, 32'(busy), 32'(m_busy));
    chk({tag, "_rw"}, 32'(rw), 32'(m_rw));
  endtask

  task automatic addr_phase(input logic [7:0] a);
    logic ack;
    write_byte(a, ack);
    chk("addr_ack", 32'(ack), 32'(model_ack(a)));
    if (model_ack(a) == 1'b0) begin
      m_busy = 1'b1;
      m_rw   = a[0];
    end else begin
      m_busy = 1'b0;
    end
    check_status("addr");
  endtask

  task automatic data_write(input logic [7:0] b);
    logic ack;
    if (m_busy && !m_rw) exp_rx_q.push_back(b);
    write_byte(b, ack);
    chk("data_ack", 32'(ack), 32'd0);
  endtask

  initial begin
    logic [7:0] d;
    logic r;
    int rx0, t0;
    rstn = 1'b0;
    scl_m = 1'b1;
    sda_m = 1'b1;
    m_busy = 1'b0;
    m_rw = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    rstn = 1'b1;
    @(negedge clk);
    chk("reset_scl_oen", 32'(scl_oen), 32'd1);
    chk("reset_sda_oen", 32'(sda_oen), 32'd1);
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_rw", 32'(rw), 32'd0);
    chk("reset_rx_data", 32'(rx_data), 32'h00);
    chk("reset_strobes", 32'({rx_valid, tx_req}), 32'd0);

    // T1: write one byte
    rx0 = rx_cnt;
    bus_start();
    addr_phase(8'hA0);
    data_write(8'h3C);
    chk("t1_busy_mid", 32'(busy), 32'd1);
    bus_stop();
    m_busy = 1'b0;
    check_status("t1_stop");
    chk("t1_rx_pulses", rx_cnt - rx0, 32'd1);
    chk("t1_rx_data", 32'(rx_data), 32'h3C);

    // T2: read two bytes, reply 5 clk after each tx_req
    t0 = treq_cnt;
    treq_limit += 2;
    resp_delay = 5;
    resp_q.push_back(8'hA5);
    resp_q.push_back(8'h0F);
    bus_start();
    addr_phase(8'hA1);
    chk("t2_rw", 32'(rw), 32'd1);
    read_byte(d, 1'b0);
    chk("t2_byte0", 32'(d), 32'hA5);
    chk("t2_stretch0", last_stretch, 32'd7);
    read_byte(d, 1'b1);
    m_busy = 1'b0;
    chk("t2_byte1", 32'(d), 32'h0F);
    chk("t2_stretch1", last_stretch, 32'd7);
    check_status("t2_nack");
    bus_stop();
    chk("t2_tx_req_pulses", treq_cnt - t0, 32'd2);
    resp_delay = 0;

    // T3: address miss
    rx0 = rx_cnt;
    t0 = treq_cnt;
    no_drive = 1'b1;
    bus_start();
    addr_phase(8'hA2);
    bus_stop();
    no_drive = 1'b0;
    chk("t3_busy", 32'(busy), 32'd0);
    chk("t3_strobes", (rx_cnt - rx0) + (treq_cnt - t0), 32'd0);

    // T4: write then repeated START and read with tx_valid held high
    rx0 = rx_cnt;
    t0 = treq_cnt;
    bus_start();
    addr_phase(8'hA0);
    chk("t4_rw_write", 32'(rw), 32'd0);
    data_write(8'h10);
    hold_data = 8'h5A;
    hold_en = 1'b1;
    treq_limit += 1;
    bus_start();
    addr_phase(8'hA1);
    chk("t4_rw_read", 32'(rw), 32'd1);
    read_byte(d, 1'b1);
    m_busy = 1'b0;
    chk("t4_byte", 32'(d), 32'h5A);
    chk("t4_stretch", last_stretch, 32'd2);
    hold_en = 1'b0;
    bus_stop();
    chk("t4_rx_pulses", rx_cnt - rx0, 32'd1);
    chk("t4_tx_req_pulses", treq_cnt - t0, 32'd1);
    chk("t4_rx_data", 32'(rx_data), 32'h10);

    // T5a: STOP after four bits of a write byte
    rx0 = rx_cnt;
    bus_start();
    addr_phase(8'hA0);
    bus_bit(1'b1, r);
    bus_bit(1'b0, r);
    bus_bit(1'b1, r);
    bus_bit(1'b1, r);
    bus_stop();
    m_busy = 1'b0;
    check_status("t5_stop");
    chk("t5_no_rx", rx_cnt - rx0, 32'd0);
    chk("t5_sda_released", 32'(sda_oen), 32'd1);

    // T5b: reset while stretching in TX_LOAD
    t0 = treq_cnt;
    treq_limit += 1;
    bus_start();
    addr_phase(8'hA1);
    wait_clk(2);
    chk("t5_stretching", 32'(scl_oen), 32'd0);
    chk("t5_tx_req", treq_cnt - t0, 32'd1);
    @(posedge clk);
    #1;
    rstn = 1'b0;
    @(posedge clk);
    #1;
    m_busy = 1'b0;
    m_rw = 1'b0;
    chk("t5_rst_scl_oen", 32'(scl_oen), 32'd1);
    chk("t5_rst_sda_oen", 32'(sda_oen), 32'd1);
    check_status("t5_rst");
    rstn = 1'b1;
    wait_clk(10);
    chk("t5_idle_no_stretch", 32'(scl_oen), 32'd1);
    chk("t5_no_new_req", treq_cnt - t0, 32'd1);
    bus_stop();
    chk("t5_final_busy", 32'(busy), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
